ofs_plat_ccip_c0_active_lines_limiter: RTL and testbench
========================================================

// Module: ofs_plat_ccip_c0_active_lines_limiter
// PURPOSE
//  Sits between AFU read-request logic and the CCI-P c0 Tx port. Counts cache lines
//  in flight on c0 and admits a new read only if the total stays within
//  MAX_ACTIVE_LINES (set from ccip_cfg_pkg::C0_MAX_BW_ACTIVE_LINES[vc]).
//  Retires lines as c0 Rx read responses arrive. Registers the Tx request once
//  (SUGGESTED_TIMING_REG_STAGES = 1).
// PARAMETERS
//  MAX_ACTIVE_LINES  512  max lines in flight; legal range 4..4095
//  HDR_W             74   width of the opaque request header passed through
// PORTS
//  pClk                 in   1      clock
//  pck_cp2af_softReset  in   1      synchronous reset, active-high
//  req_valid            in   1      upstream read request valid
//  req_ready            out  1      request accepted this cycle when valid&ready
//  req_hdr              in   HDR_W  request header, forwarded unmodified
//  req_cl_len           in   2      0=1 line, 1=2 lines, 3=4 lines, 2=illegal
//  c0_almFull           in   1      FIU c0 Tx almost-full
//  c0_tx_valid          out  1      registered request valid toward FIU
//  c0_tx_hdr            out  HDR_W  registered request header
//  rsp_valid            in   1      c0 Rx read response valid
//  rsp_format           in   1      1 = packed response covering the whole request
//  rsp_cl_len           in   2      cl_len of the original request (used if format=1)
//  active_lines         out  clog2(MAX_ACTIVE_LINES+1)  current lines in flight
//  peak_active_lines    out  same   high-water mark since reset
//  err_underflow        out  1      sticky: a response arrived with count too low
//  err_bad_len          out  1      sticky: accepted request with req_cl_len==2
// BEHAVIOUR
//  Reset: c0_tx_valid=0, c0_tx_hdr=0, active_lines=0, peak=0, both err flags=0.
//  Line count: nreq = {1,2,4,4}[req_cl_len]. cl_len==2 is charged as 4 lines and
//   sets err_bad_len on acceptance.
//  req_ready = !c0_almFull && (active_lines + nreq <= MAX_ACTIVE_LINES).
//   This is combinational in req_cl_len, so upstream holds hdr/cl_len stable while
//   valid. Uses the registered count only; same-cycle retirement does not widen
//   admission.
//  Accept at cycle N (req_valid && req_ready): c0_tx_valid=1 and c0_tx_hdr=req_hdr
//   at N+1. Otherwise c0_tx_valid=0 at N+1 and the header register holds its value.
//   c0_almFull is honoured at acceptance only; a registered request is always issued.
//  Retire count ndec: if rsp_valid, ndec = rsp_format ? {1,2,4,4}[rsp_cl_len] : 1;
//   otherwise ndec = 0.
//  Next count = active_lines + (accept ? nreq : 0) - ndec, computed in one cycle.
//   The count is incremented at acceptance, not at Tx.
//  Underflow: if active_lines + inc < ndec, next count=0 and err_underflow is set.
//  peak_active_lines <= max(peak, next count). Error flags clear only on reset.
//  Count is never allowed above MAX_ACTIVE_LINES. Tx is one-deep, so there is no
//   further buffering.
//  Reset mid-flight: all state cleared. Responses to pre-reset requests trigger
//   underflow handling: count saturates at 0 and the flag is set.
// TESTING  (MAX_ACTIVE_LINES=8 unless noted)
//  1. Reset, then one 1-line req with hdr=0x5A -> c0_tx_valid 1 cycle later with
//     hdr 0x5A; active_lines=1. After rsp(format=0) -> active_lines=0.
//  2. Two cl_len=3 reqs back-to-back -> both accepted, count=8. A third
//     1-line req -> req_ready=0 until a response; after rsp(format=1,len=3)
//     -> accepted, count=5.
//  3. count=7, a 2-line req and a 1-line rsp in the same cycle -> req_ready=0;
//     next cycle count=6 and the req is accepted; count=8, peak=8.
//  4. c0_almFull=1 with count=0 -> req_ready=0 and no tx_valid. Deassert ->
//     accepted 1 cycle later.
//  5. rsp_valid with count=0 -> count stays 0 and err_underflow=1 (sticky).
//     Accept with cl_len=2 -> count += 4 and err_bad_len=1.
//  6. Reset asserted with count=6 and tx_valid=1 -> next cycle all outputs are 0.
//     Random traffic against a reference model: count==model and count<=MAX.

Source files
------------

// File: rtl/ofs_plat_ccip_c0_active_lines_limiter.sv
// ofs_plat_ccip_c0_active_lines_limiter
//
// Throttles CCI-P c0 read requests so that the number of cache lines in
// flight never exceeds MAX_ACTIVE_LINES.
//
// How it works:
//  - Lines are charged when the upstream request is accepted.
//  - Lines are retired when c0 Rx read responses arrive.
//  - An accepted request is registered once and is then always issued to
//    the FIU on the following cycle.
//  - A retirement larger than the current count saturates the count at zero
//    and raises a sticky underflow flag. This is the expected result when
//    responses arrive for requests issued before a reset.

module ofs_plat_ccip_c0_active_lines_limiter #(
  parameter int MAX_ACTIVE_LINES = 512,
  parameter int HDR_W            = 74
) (
  input  logic                                    pClk,
  input  logic                                    pck_cp2af_softReset,

  // Upstream read requests
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [HDR_W-1:0]                        req_hdr,
  input  logic [1:0]                              req_cl_len,

  // c0 Tx toward the FIU
  input  logic                                    c0_almFull,
  output logic                                    c0_tx_valid,
  output logic [HDR_W-1:0]                        c0_tx_hdr,

  // c0 Rx read responses
  input  logic                                    rsp_valid,
  input  logic                                    rsp_format,
  input  logic [1:0]                              rsp_cl_len,

  // Status
  output logic [$clog2(MAX_ACTIVE_LINES+1)-1:0]   active_lines,
  output logic [$clog2(MAX_ACTIVE_LINES+1)-1:0]   peak_active_lines,
  output logic                                    err_underflow,
  output logic                                    err_bad_len
);

  localparam int CNT_W = $clog2(MAX_ACTIVE_LINES + 1);
  // Three extra bits of headroom so that count + 4 cannot wrap.
  localparam int SUM_W = CNT_W + 3;

  localparam logic [SUM_W-1:0] MAX_LINES = SUM_W'(MAX_ACTIVE_LINES);

  // State
  logic [CNT_W-1:0] count_reg,     count_next;
  logic [CNT_W-1:0] peak_reg,      peak_next;
  logic             underflow_reg, underflow_next;
  logic             bad_len_reg,   bad_len_next;
  logic             tx_valid_reg;
  logic [HDR_W-1:0] tx_hdr_reg;

  // Datapath intermediates
  logic [2:0]       req_lines;
  logic [2:0]       rsp_lines;
  logic [SUM_W-1:0] admit_sum;
  logic [SUM_W-1:0] inc_sum;
  logic [SUM_W-1:0] dec_lines;
  logic             accept;

  // Line cost of the request and of a packed response.
  // The reserved encoding cl_len==2 is charged as 4 lines, which is the
  // conservative choice.
  always_comb begin
    req_lines = 3'd4;
    case (req_cl_len)
      2'd0:    req_lines = 3'd1;
      2'd1:    req_lines = 3'd2;
      default: req_lines = 3'd4;
    endcase

    rsp_lines = 3'd4;
    case (rsp_cl_len)
      2'd0:    rsp_lines = 3'd1;
      2'd1:    rsp_lines = 3'd2;
      default: rsp_lines = 3'd4;
    endcase
  end

  // Admission test.
  // Only the registered count is used, so a retirement in the same cycle
  // never widens admission. This also keeps req_ready off the Rx path.
  always_comb begin
    admit_sum = SUM_W'(count_reg) + SUM_W'(req_lines);
    req_ready = !c0_almFull && (admit_sum <= MAX_LINES);
    accept    = req_valid && req_ready;
  end

  // Next-state computation for the counter, the peak and the sticky flags.
  always_comb begin
    // Lines charged this cycle
    inc_sum = SUM_W'(count_reg);
    if (accept) begin
      inc_sum = SUM_W'(count_reg) + SUM_W'(req_lines);
    end

    // Lines retired this cycle.
    // An unpacked response retires one line per beat; a packed response
    // retires the whole request at once.
    dec_lines = '0;
    if (rsp_valid) begin
      dec_lines = rsp_format ? SUM_W'(rsp_lines) : SUM_W'(1);
    end

    underflow_next = underflow_reg;
    if (inc_sum < dec_lines) begin
      count_next     = '0;
      underflow_next = 1'b1;
    end else begin
      count_next     = CNT_W'(inc_sum - dec_lines);
    end

    peak_next = (count_next > peak_reg) ? count_next : peak_reg;

    bad_len_next = bad_len_reg;
    if (accept && (req_cl_len == 2'd2)) begin
      bad_len_next = 1'b1;
    end
  end

  // Counter, peak and sticky error state.
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      count_reg     <= '0;
      peak_reg      <= '0;
      underflow_reg <= 1'b0;
      bad_len_reg   <= 1'b0;
    end else begin
      count_reg     <= count_next;
      peak_reg      <= peak_next;
      underflow_reg <= underflow_next;
      bad_len_reg   <= bad_len_next;
    end
  end

  // One-deep Tx register.
  // c0_almFull was already honoured at acceptance, so a registered request
  // is always issued. The header holds its value when nothing is accepted.
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      tx_valid_reg <= 1'b0;
      tx_hdr_reg   <= '0;
    end else begin
      tx_valid_reg <= accept;
      if (accept) begin
        tx_hdr_reg <= req_hdr;
      end
    end
  end

  assign c0_tx_valid       = tx_valid_reg;
  assign c0_tx_hdr         = tx_hdr_reg;
  assign active_lines      = count_reg;
  assign peak_active_lines = peak_reg;
  assign err_underflow     = underflow_reg;
  assign err_bad_len       = bad_len_reg;

endmodule

// File: tb/tb_ofs_plat_ccip_c0_active_lines_limiter.sv
// Testbench for ofs_plat_ccip_c0_active_lines_limiter (MAX_ACTIVE_LINES = 8).
//
// Stimulus:
//  - Directed scenarios first.
//  - Then randomized traffic.
//
// Checking:
//  - Every cycle is compared against a reference model of the line-accounting
//    rules.
//  - The model keeps an integer count, the peak, the sticky flags and the
//    expected Tx output.

module tb_ofs_plat_ccip_c0_active_lines_limiter;

  localparam int MAX   = 8;
  localparam int HDR_W = 74;
  localparam int CW    = $clog2(MAX + 1);

  logic              pClk = 1'b0;
  logic              srst;
  logic              req_valid;
  logic              req_ready;
  logic [HDR_W-1:0]  req_hdr;
  logic [1:0]        req_cl_len;
  logic              c0_almFull;
  logic              c0_tx_valid;
  logic [HDR_W-1:0]  c0_tx_hdr;
  logic              rsp_valid;
  logic              rsp_format;
  logic [1:0]        rsp_cl_len;
  logic [CW-1:0]     active_lines;
  logic [CW-1:0]     peak_active_lines;
  logic              err_underflow;
  logic              err_bad_len;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int               m_count;
  int               m_peak;
  bit               m_uf;
  bit               m_bl;
  bit               m_txv;
  logic [HDR_W-1:0] m_txh;

  always #5 pClk = ~pClk;

  ofs_plat_ccip_c0_active_lines_limiter #(
    .MAX_ACTIVE_LINES (MAX),
    .HDR_W            (HDR_W)
  ) dut (
    .pClk                (pClk),
    .pck_cp2af_softReset (srst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_hdr             (req_hdr),
    .req_cl_len          (req_cl_len),
    .c0_almFull          (c0_almFull),
    .c0_tx_valid         (c0_tx_valid),
    .c0_tx_hdr           (c0_tx_hdr),
    .rsp_valid           (rsp_valid),
    .rsp_format          (rsp_format),
    .rsp_cl_len          (rsp_cl_len),
    .active_lines        (active_lines),
    .peak_active_lines   (peak_active_lines),
    .err_underflow       (err_underflow),
    .err_bad_len         (err_bad_len)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line count for a cl_len code: {1,2,4,4}
  function automatic int lines(input logic [1:0] l);
    case (l)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  task automatic idle();
    req_valid  = 1'b0;
    req_cl_len = 2'd0;
    c0_almFull = 1'b0;
    rsp_valid  = 1'b0;
    rsp_format = 1'b0;
    rsp_cl_len = 2'd0;
  endtask

  task automatic model_reset();
    m_count = 0;
    m_peak  = 0;
    m_uf    = 1'b0;
    m_bl    = 1'b0;
    m_txv   = 1'b0;
    m_txh   = '0;
  endtask

  // One clock cycle.
  // Inputs are already set by the caller. The task:
  //  1. checks the combinational ready,
  //  2. advances the model across the edge,
  //  3. checks all registered outputs.
  task automatic tick();
    bit acc;
    bit exp_ready;
    int total;
    int dec;
    #1;
    exp_ready = !c0_almFull && (m_count + lines(req_cl_len) <= MAX);
    check_eq("req_ready", 128'(req_ready), 128'(exp_ready));
    acc   = req_valid && exp_ready;
    total = m_count + (acc ? lines(req_cl_len) : 0);
    dec   = rsp_valid ? (rsp_format ? lines(rsp_cl_len) : 1) : 0;
    @(posedge pClk);
    if (srst) begin
      model_reset();
    end else begin
      if (total < dec) begin
        m_count = 0;
        m_uf    = 1'b1;
      end else begin
        m_count = total - dec;
      end
      if (m_count > m_peak) m_peak = m_count;
      if (acc && req_cl_len == 2'd2) m_bl = 1'b1;
      m_txv = acc;
      if (acc) m_txh = req_hdr;
    end
    #1;
    check_eq("c0_tx_valid",   128'(c0_tx_valid),       128'(m_txv));
    check_eq("c0_tx_hdr",     128'(c0_tx_hdr),         128'(m_txh));
    check_eq("active_lines",  128'(active_lines),      128'(m_count));
    check_eq("peak",          128'(peak_active_lines), 128'(m_peak));
    check_eq("err_underflow", 128'(err_underflow),     128'(m_uf));
    check_eq("err_bad_len",   128'(err_bad_len),       128'(m_bl));
    check_eq("count_le_max",  128'(active_lines <= CW'(MAX)), 128'(1));
  endtask

  task automatic do_reset();
    idle();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic send(input logic [1:0] len, input logic [HDR_W-1:0] hdr);
    req_valid  = 1'b1;
    req_cl_len = len;
    req_hdr    = hdr;
  endtask

  initial begin
    idle();
    req_hdr = '0;
    srst    = 1'b1;
    model_reset();
    @(posedge pClk);
    #1;

    // Reset values
    tick();
    srst = 1'b0;
    check_eq("reset_tx_valid", 128'(c0_tx_valid),  128'(0));
    check_eq("reset_count",    128'(active_lines), 128'(0));

    // 1. Single 1-line request, then an unpacked response
    send(2'd0, HDR_W'(74'h5A));
    tick();
    check_eq("t1_hdr", 128'(c0_tx_hdr), 128'(74'h5A));
    idle();
    tick();
    rsp_valid = 1'b1;
    tick();
    idle();
    check_eq("t1_count0", 128'(active_lines), 128'(0));

    // 2. Two 4-line requests fill the budget; a 1-line request stalls
    //    until a packed 4-line response is retired
    send(2'd3, HDR_W'(74'h111));
    tick();
    send(2'd3, HDR_W'(74'h222));
    tick();
    check_eq("t2_full", 128'(active_lines), 128'(8));
    send(2'd0, HDR_W'(74'h333));
    tick();
    tick();
    rsp_valid  = 1'b1;
    rsp_format = 1'b1;
    rsp_cl_len = 2'd3;
    tick();
    rsp_valid = 1'b0;
    tick();
    check_eq("t2_count5", 128'(active_lines), 128'(5));

    // 3. Reach 7. A 2-line request arriving with a same-cycle retirement
    //    is refused; it is accepted on the next cycle
    send(2'd1, HDR_W'(74'h444));
    tick();
    send(2'd1, HDR_W'(74'h555));
    rsp_valid  = 1'b1;
    rsp_format = 1'b0;
    tick();
    rsp_valid = 1'b0;
    tick();
    idle();
    check_eq("t3_count8", 128'(active_lines),      128'(8));
    check_eq("t3_peak8",  128'(peak_active_lines), 128'(8));

    // 4. Almost-full blocks admission
    do_reset();
    send(2'd0, HDR_W'(74'h666));
    c0_almFull = 1'b1;
    tick();
    tick();
    c0_almFull = 1'b0;
    tick();
    idle();
    tick();

    // 5. Underflow on an empty count; accepted request with the reserved length
    do_reset();
    rsp_valid = 1'b1;
    tick();
    idle();
    tick();
    check_eq("t5_uf_sticky", 128'(err_underflow), 128'(1));
    send(2'd2, HDR_W'(74'h777));
    tick();
    idle();
    check_eq("t5_bad_len", 128'(err_bad_len), 128'(1));

    // 6. Reset while count=6 and a request is being issued
    do_reset();
    send(2'd3, HDR_W'(74'h888));
    tick();
    send(2'd1, HDR_W'(74'h999));
    tick();
    idle();
    check_eq("t6_pre_count", 128'(active_lines), 128'(6));
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_eq("t6_post_tx", 128'(c0_tx_valid),  128'(0));
    check_eq("t6_post_cnt", 128'(active_lines), 128'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      srst       = ($urandom_range(0, 299) == 0);
      req_valid  = ($urandom_range(0, 1) == 1);
      req_cl_len = 2'($urandom_range(0, 3));
      req_hdr    = HDR_W'({$urandom(), $urandom(), $urandom()});
      c0_almFull = ($urandom_range(0, 3) == 0);
      rsp_valid  = ($urandom_range(0, 2) == 0);
      rsp_format = 1'($urandom_range(0, 1));
      rsp_cl_len = 2'($urandom_range(0, 3));
      tick();
    end

    srst = 1'b0;
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
